// File: rtl/arb_rr_4.sv
// Four-way round-robin arbiter producing a registered one-hot grant with a
// programmable hold limit; a forced release pulses timeout for one cycle.
module arb_rr_4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    logic [0:0] state;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic [1:0] g;

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] offs;
    logic [1:0] winner;

    // Rotating the request vector so bit 0 is the ptr requester turns the
    // round-robin scan into a fixed-priority encode.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[{1'b0, ptr} +: 4];

    always_comb begin
        offs = 2'd0;
        if (req_rot[0]) begin
            offs = 2'd0;
        end else if (req_rot[1]) begin
            offs = 2'd1;
        end else if (req_rot[2]) begin
            offs = 2'd2;
        end else begin
            offs = 2'd3;
        end
    end

    assign winner = ptr + offs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= 8'd0;
            g       <= 2'd0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        grant <= 4'b0001 << winner;
                        busy  <= 1'b1;
                        g     <= winner;
                        cnt   <= 8'd0;
                        ptr   <= winner + 2'd1;
                    end
                end
                GRANT: begin
                    // done and a dropped request take precedence over the hold limit.
                    if (done || !req[g]) begin
                        state <= IDLE;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        cnt   <= 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= IDLE;
                        grant   <= 4'b0000;
                        busy    <= 1'b0;
                        cnt     <= 8'd0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/arb_rr_4.md
# arb_rr_4

Four-way round-robin arbiter that sits directly upstream of the 4-to-2 encoder. It turns up to four concurrent request lines into a registered one-hot grant, which the encoder converts to a 2-bit index. Grants are held until the requester signals completion, drops its request, or exceeds a programmable hold limit. Rotating priority guarantees that no requester starves.

## Interface
- `HOLD_MAX`, default 15: maximum number of consecutive cycles one grant may stay asserted. Legal range is 1..255.
- `clk`, input, 1: single clock; everything is sampled on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: request lines; bit i is requester i. A requester holds its bit high for as long as it wants the grant.
- `done`, input, 1: the current grant holder finishes this cycle. Ignored when no grant is active.
- `grant`, output, 4: registered one-hot grant; 4'b0000 when idle. Feeds the encoder input directly.
- `busy`, output, 1: registered; equals |grant.
- `timeout`, output, 1: registered one-cycle pulse, high in the cycle a grant is forcibly released by the hold limit.

## Operation
- Two states:
  - IDLE: grant = 0.
  - GRANT: exactly one grant bit set.
- Internal state:
  - `ptr[1:0]` is the highest-priority requester index.
  - `cnt[7:0]` is the hold counter.
  - Winner index `g[1:0]` is registered alongside `grant`.
- IDLE, at each edge:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner: the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register `grant` = 1<<winner and `g` = winner, set cnt = 0, go to GRANT.
  - Update ptr = (winner+1) mod 4 at the same edge.
- GRANT, at each edge, checked in this priority order:
  - If done = 1, or req[g] = 0: release. Grant goes to 0, go to IDLE, no timeout.
  - Else if cnt == HOLD_MAX-1: release. Grant goes to 0, go to IDLE, timeout = 1 for that one cycle.
  - Else: cnt = cnt+1, grant unchanged.
- Requests from other requesters during GRANT are ignored; they are arbitrated in the next IDLE cycle.
- A forcibly released requester that still requests has the lowest priority at re-arbitration, because ptr has already passed it.
- grant is never multi-hot. It can change only 0 to one-hot or one-hot to 0, never one-hot to a different one-hot directly.
- Widths: cnt is 8 bits and never exceeds HOLD_MAX-1. ptr wraps 3 to 0.

## Timing
- Reset values:
  - grant = 4'b0000, busy = 0, timeout = 0
  - state = IDLE, ptr = 0, cnt = 0, g = 0
- Reset assertion clears all outputs immediately, without waiting for a clock edge, including mid-grant. The first arbitration happens at the first rising edge after rst_n is released.
- Latency:
  - A request present at an IDLE edge sees grant asserted the following cycle (1 cycle).
  - done or a req drop sampled at an edge deasserts grant the following cycle.
- After every release there is exactly one IDLE cycle with grant = 0 before any new grant.
  - Back-to-back service of four always-requesting requesters takes 2 cycles per grant when done is pulsed on the first grant cycle.
- Maximum continuous grant is HOLD_MAX cycles.
  - With HOLD_MAX = 1, every grant lasts exactly one cycle. timeout pulses on every release unless done is high or the request has dropped.
- If done and the hold limit coincide on the last cycle, done wins and timeout stays 0.
- timeout is high only in the IDLE cycle immediately after a forced release. It is never high for two consecutive cycles.

## Test plan
- **Reset, then full contention.** Apply reset, then hold req = 4'b1111. Expected: all outputs 0 during reset; grant = 4'b0001 one cycle after the first edge following release.
- **Rotation.** Hold req = 4'b1111 and pulse done on each grant cycle. Expected grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001; timeout stays 0 throughout.
- **Hold limit.** With HOLD_MAX = 4, hold req = 4'b0100 and done = 0. Expected:
  - grant = 0100 for exactly 4 cycles;
  - then grant = 0000 with timeout = 1 for one cycle;
  - then grant = 0100 again.
- **Request drop and skip.** With ptr = 0, apply req = 4'b1000. Expected: grant = 1000 (requesters 0..2 skipped). Then drop req[3] without done. Expected: grant = 0000 the next cycle, timeout = 0, ptr = 0.
- **Reset mid-grant.** While grant = 0010 and cnt = 2, pull rst_n low between edges. Expected: grant, busy and timeout go to 0 immediately. After release with req = 4'b1111: grant = 0001, confirming ptr was reset.
- **Done on the last hold cycle.** With HOLD_MAX = 3, assert done on the 3rd grant cycle. Expected: release with timeout = 0.
